nibble_add_ctrl: RTL and testbench

NIBBLE_ADD_CTRL -- requirements
Module: nibble_add_ctrl

---
 rtl/nibble_add_ctrl_pkg.sv | 15 +
 rtl/adder4_slice.sv | 24 ++
 rtl/nibble_add_ctrl.sv | 126 ++++++++++++
 tb/tb_nibble_add_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_add_ctrl_pkg;

  localparam int unsigned SLICE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/adder4_slice.sv
// Combinational 4-bit ripple adder slice; also exposes the carry into bit 3.
module adder4_slice
  import nibble_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W-1:0] low;
  logic [1:0]         high;

  // Split at bit 3 so the MSB carry-in is available for overflow detection.
  assign low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
  assign c3   = low[SLICE_W-1];
  assign high = {1'b0, a[SLICE_W-1]} + {1'b0, b[SLICE_W-1]} + {1'b0, c3};

  assign s    = {high[0], low[SLICE_W-2:0]};
  assign cout = high[1];

endmodule

// File: rtl/nibble_add_ctrl.sv
// Nibble-serial adder/subtractor: one shared 4-bit slice, LSB nibble first,
// IDLE -> RUN (NIBBLES cycles) -> DONE (one-cycle done pulse).
module nibble_add_ctrl
  import nibble_add_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W    = SLICE_W * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_nib, b_nib, s_nib;
  logic               slice_cout, slice_c3;

  // Only indices 0..NIBBLES-1 can select a nibble; anything else yields zero.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_nib = a_q[SLICE_W*i +: SLICE_W];
        b_nib = b_q[SLICE_W*i +: SLICE_W];
      end
    end
  end

  adder4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          // Subtract as A + ~B + 1: the +1 enters as the initial carry.
          b_d     = (op == OP_SUB) ? ~b : b;
          idx_d   = '0;
          carry_d = op;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) sum_d[SLICE_W*i +: SLICE_W] = s_nib;
        end
        carry_d = slice_cout;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = slice_c3 ^ slice_cout;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun) || (state_q == StDone);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_ctrl.sv
// Self-checking bench for nibble_add_ctrl: directed cases plus randomized
// operations checked against a whole-word arithmetic reference model.
module tb_nibble_add_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_add_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Returns {ovf, cout, sum} computed from integer arithmetic on the full words.
  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0] r;
    int sx, sy, res;
    logic v;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o) begin
      r   = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
      res = sx - sy;
    end else begin
      r   = {1'b0, x} + {1'b0, y};
      res = sx + sy;
    end
    v = (res > 32767) || (res < -32768);
    return {v, r};
  endfunction

  // Launch one operation, scramble inputs during RUN, and check latency/results.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit sync);
    logic [W+1:0] exp;
    int cyc;
    exp = model(o, x, y);
    if (sync) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, 5);
    check({tag, ".sum"}, sum, exp[W-1:0]);
    check({tag, ".cout"}, cout, exp[W]);
    check({tag, ".ovf"}, ovf, exp[W+1]);
    check({tag, ".busy_done"}, busy, 1);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".busy_idle"}, busy, 0);
    check({tag, ".sum_hold"}, sum, exp[W-1:0]);
  endtask

  initial begin
    int dcnt;
    int low_run;
    int seen;
    int last_t;
    logic [W-1:0] got;
    logic [W-1:0] ra, rb;
    logic         ro;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);

    // First start lands on the first rising edge after reset release.
    @(negedge clk); rst_n = 1'b1;
    run_op("add0", 1'b0, 16'h0000, 16'h0000, 1'b0);
    run_op("addwrap", 1'b0, 16'hFFFF, 16'h0001, 1'b1);
    run_op("addovf", 1'b0, 16'h7FFF, 16'h0001, 1'b1);
    run_op("sub5m3", 1'b1, 16'h0005, 16'h0003, 1'b1);
    run_op("sub3m5", 1'b1, 16'h0003, 16'h0005, 1'b1);
    run_op("subovf", 1'b1, 16'h8000, 16'h0001, 1'b1);

    // Start re-pulsed mid-operation must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h0008; b = 16'h0001;
    dcnt = 0; got = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin dcnt++; got = sum; end
    end
    start = 1'b1; op = 1'b1; a = 16'h00F0; b = 16'h0F00;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin dcnt++; got = sum; end
    end
    check("ignore.done_count", dcnt, 1);
    check("ignore.sum", got, 16'h0009);

    // Reset mid-RUN aborts the operation with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h1111;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("abort.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.sum", sum, 0);
    check("abort.cout", cout, 0);
    check("abort.ovf", ovf, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort.no_done", dcnt, 0);
    run_op("after_abort", 1'b0, 16'h1234, 16'h1111, 1'b1);

    // Start held high: back-to-back operations, one IDLE cycle between.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h00FF; b = 16'h0F01;
    seen = 0; last_t = 0; low_run = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      if (done) begin
        check("held.sum", sum, 16'h1000);
        check("held.cout", cout, 0);
        if (seen > 0) check("held.period", t - last_t, 6);
        seen++;
        last_t = t;
      end
      if (!busy) low_run++;
      else begin
        if (low_run > 0 && seen > 0) check("held.idle_gap", low_run, 1);
        low_run = 0;
      end
    end
    check("held.done_count", seen, 3);
    start = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
